// File: rtl/ws2812_frame_sched_if.sv
// Bus between the two frame producers, the ws2812 driver and the frame scheduler.
// The scheduler connects through the slave modport; the environment uses master.
interface ws2812_frame_sched_if;
    logic [1:0]   req;
    logic [255:0] frame0;
    logic [255:0] frame1;
    logic [1:0]   ack;
    logic         drv_busy;
    logic         drv_update;
    logic [255:0] drv_matrix;
    logic         active_src;
    logic [15:0]  frame_count;
    logic         err_timeout;

    modport master (
        output req, frame0, frame1, drv_busy,
        input  ack, drv_update, drv_matrix, active_src, frame_count, err_timeout
    );

    modport slave (
        input  req, frame0, frame1, drv_busy,
        output ack, drv_update, drv_matrix, active_src, frame_count, err_timeout
    );
endinterface

// File: rtl/ws2812_frame_sched.sv
// Round-robin frame scheduler in front of the ws2812 matrix driver: grants one of two
// producers, latches its matrix, pulses the driver update, tracks one refresh, enforces a
// minimum update period and flags a driver that never starts.
module ws2812_frame_sched #(
    parameter int unsigned MIN_PERIOD    = 400000,
    parameter int unsigned START_TIMEOUT = 16
) (
    input logic                  clock,
    input logic                  reset,
    ws2812_frame_sched_if.slave  bus
);

    localparam int unsigned HoldW = (MIN_PERIOD > 1) ? $clog2(MIN_PERIOD) : 1;
    localparam int unsigned WaitW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(MIN_PERIOD - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(START_TIMEOUT - 1);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StWaitBusy = 2'd1;
    localparam logic [1:0] StWaitDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       ack_q, ack_d;
    logic             update_q, update_d;
    logic [255:0]     matrix_q, matrix_d;
    logic             active_q, active_d;
    logic             last_grant_q, last_grant_d;
    logic [HoldW-1:0] holdoff_q, holdoff_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [15:0]      count_q, count_d;
    logic             err_q, err_d;

    logic sel;
    logic can_grant;

    // Lone requester wins; on a tie the source not granted last time wins.
    assign sel       = bus.req[1] & (~bus.req[0] | ~last_grant_q);
    assign can_grant = (bus.req != 2'b00) && (holdoff_q == '0) && !bus.drv_busy;

    // Next-state logic for the grant / refresh-tracking FSM and its counters.
    always_comb begin
        state_d      = state_q;
        ack_d        = 2'b00;
        update_d     = 1'b0;
        matrix_d     = matrix_q;
        active_d     = active_q;
        last_grant_d = last_grant_q;
        wait_d       = wait_q;
        count_d      = count_q;
        err_d        = err_q;
        // Holdoff runs down regardless of state; a grant reloads it below.
        holdoff_d    = (holdoff_q != '0) ? holdoff_q - HoldW'(1) : holdoff_q;

        case (state_q)
            StIdle: begin
                if (can_grant) begin
                    matrix_d     = sel ? bus.frame1 : bus.frame0;
                    ack_d        = sel ? 2'b10 : 2'b01;
                    update_d     = 1'b1;
                    active_d     = sel;
                    last_grant_d = sel;
                    wait_d       = '0;
                    holdoff_d    = HoldLoad;
                    state_d      = StWaitBusy;
                end
            end
            StWaitBusy: begin
                if (bus.drv_busy) begin
                    state_d = StWaitDone;
                end else if (wait_q == WaitLast) begin
                    // Driver never started: drop the frame, keep scheduling.
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWaitDone: begin
                if (!bus.drv_busy) begin
                    count_d = count_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            ack_q        <= 2'b00;
            update_q     <= 1'b0;
            matrix_q     <= '0;
            active_q     <= 1'b0;
            last_grant_q <= 1'b1;
            holdoff_q    <= '0;
            wait_q       <= '0;
            count_q      <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            update_q     <= update_d;
            matrix_q     <= matrix_d;
            active_q     <= active_d;
            last_grant_q <= last_grant_d;
            holdoff_q    <= holdoff_d;
            wait_q       <= wait_d;
            count_q      <= count_d;
            err_q        <= err_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.drv_update  = update_q;
    assign bus.drv_matrix  = matrix_q;
    assign bus.active_src  = active_q;
    assign bus.frame_count = count_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Self-checking bench for ws2812_frame_sched: directed and randomized frame transactions
// checked against a transaction-level model of grant order, grant time and refresh count.
module tb_ws2812_frame_sched;

    localparam int unsigned MinP = 40;
    localparam int unsigned StartTo = 16;

    logic clock;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    // Model state
    logic       last_grant_m;
    int         prev_grant_edge;
    logic [15:0] count_m;
    logic       err_m;

    ws2812_frame_sched_if bus ();

    ws2812_frame_sched #(
        .MIN_PERIOD    (MinP),
        .START_TIMEOUT (StartTo)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Edge counter: at a negedge, cyc is the index of the posedge just taken.
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        last_grant_m    = 1'b1;
        prev_grant_edge = -1000;
        count_m         = 16'd0;
        err_m           = 1'b0;
    endtask

    // One frame: request after gap, optional busy-in-idle block, then either a normal
    // refresh, a driver that never starts, or a reset while the refresh is in progress.
    task automatic run_frame(input logic [1:0] pattern, input int gap, input int pre_busy,
                             input bit no_start, input int start_dly, input int dur,
                             input bit reset_mid);
        int           c;
        int           exp_edge;
        int           g;
        logic         exp_sel;
        logic [255:0] f0;
        logic [255:0] f1;
        logic [255:0] exp_frame;
        bit           got;

        repeat (gap) @(negedge clock);
        f0 = rand256();
        f1 = rand256();
        bus.frame0   = f0;
        bus.frame1   = f1;
        bus.req      = pattern;
        bus.drv_busy = (pre_busy > 0);
        c = cyc;
        exp_edge  = (c + pre_busy + 1 > prev_grant_edge + int'(MinP)) ?
                    c + pre_busy + 1 : prev_grant_edge + int'(MinP);
        exp_sel   = (pattern == 2'b11) ? ~last_grant_m : pattern[1];
        exp_frame = exp_sel ? f1 : f0;

        got = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (bus.ack != 2'b00) begin
                got = 1'b1;
                break;
            end
            if (cyc >= c + pre_busy) bus.drv_busy = 1'b0;
        end
        chk("grant_seen", 256'(got), 256'(1'b1));
        if (!got) begin
            bus.req = 2'b00;
            return;
        end
        chk("grant_edge", 256'(cyc), 256'(exp_edge));
        chk("ack", 256'(bus.ack), 256'(exp_sel ? 2'b10 : 2'b01));
        chk("drv_update", 256'(bus.drv_update), 256'(1'b1));
        chk("drv_matrix", bus.drv_matrix, exp_frame);
        chk("active_src", 256'(bus.active_src), 256'(exp_sel));
        bus.req      = 2'b00;
        bus.drv_busy = 1'b0;
        last_grant_m    = exp_sel;
        prev_grant_edge = exp_edge;
        g = cyc;

        @(negedge clock);
        chk("ack_pulse", 256'(bus.ack), 256'(2'b00));
        chk("update_pulse", 256'(bus.drv_update), 256'(1'b0));

        if (no_start) begin
            while (cyc < g + int'(StartTo) - 1) @(negedge clock);
            if (!err_m) chk("err_early", 256'(bus.err_timeout), 256'(1'b0));
            @(negedge clock);
            err_m = 1'b1;
            chk("err_timeout", 256'(bus.err_timeout), 256'(err_m));
            chk("count_after_to", 256'(bus.frame_count), 256'(count_m));
        end else begin
            repeat (start_dly) @(negedge clock);
            bus.drv_busy = 1'b1;
            if (reset_mid) begin
                repeat (3) @(negedge clock);
                reset = 1'b0;
                @(negedge clock);
                chk("rst_ack", 256'(bus.ack), 256'(2'b00));
                chk("rst_update", 256'(bus.drv_update), 256'(1'b0));
                chk("rst_matrix", bus.drv_matrix, 256'(0));
                chk("rst_active", 256'(bus.active_src), 256'(1'b0));
                chk("rst_count", 256'(bus.frame_count), 256'(0));
                chk("rst_err", 256'(bus.err_timeout), 256'(1'b0));
                reset        = 1'b1;
                bus.drv_busy = 1'b0;
                model_reset();
                return;
            end
            repeat (dur) @(negedge clock);
            bus.drv_busy = 1'b0;
            @(negedge clock);
            count_m = count_m + 16'd1;
            chk("frame_count", 256'(bus.frame_count), 256'(count_m));
            chk("matrix_hold", bus.drv_matrix, exp_frame);
            chk("err_sticky", 256'(bus.err_timeout), 256'(err_m));
        end
    endtask

    initial begin
        logic [1:0] pat;
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        bus.req      = 2'b00;
        bus.frame0   = '0;
        bus.frame1   = '0;
        bus.drv_busy = 1'b0;
        model_reset();

        repeat (3) @(negedge clock);
        chk("reset_ack", 256'(bus.ack), 256'(2'b00));
        chk("reset_update", 256'(bus.drv_update), 256'(1'b0));
        chk("reset_matrix", bus.drv_matrix, 256'(0));
        chk("reset_active", 256'(bus.active_src), 256'(1'b0));
        chk("reset_count", 256'(bus.frame_count), 256'(0));
        chk("reset_err", 256'(bus.err_timeout), 256'(1'b0));
        reset = 1'b1;

        // Single grant from source 0.
        run_frame(2'b01, 0, 0, 1'b0, 0, 8, 1'b0);
        // Round-robin with both sources requesting; back-to-back hits the rate limit.
        for (int i = 0; i < 4; i++) run_frame(2'b11, 0, 0, 1'b0, 1, 6, 1'b0);
        // Rate limit with a single persistent requester.
        for (int i = 0; i < 2; i++) run_frame(2'b01, 0, 0, 1'b0, 0, 9, 1'b0);
        // Busy held in idle blocks the grant well past the holdoff.
        run_frame(2'b10, 0, 60, 1'b0, 2, 4, 1'b0);
        // Driver never starts, then scheduling continues.
        run_frame(2'b01, 0, 0, 1'b1, 0, 0, 1'b0);
        run_frame(2'b11, 0, 0, 1'b0, 3, 5, 1'b0);

        // Randomized transactions.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       pat = 2'b01;
                1:       pat = 2'b10;
                default: pat = 2'b11;
            endcase
            run_frame(pat, $urandom_range(0, 50),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 50) : 0,
                      ($urandom_range(0, 5) == 0), $urandom_range(0, 3),
                      $urandom_range(1, 12), 1'b0);
        end

        // Reset during refresh, then a tie must go to source 0 immediately.
        run_frame(2'b10, 45, 0, 1'b0, 1, 0, 1'b1);
        run_frame(2'b11, 0, 0, 1'b0, 1, 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
